gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Shares one GCD engine (control FSM plus datapath) between NREQ requesters using a round-robin scheme.
- Accepts operand pairs over per-requester valid/ready, drives the engine's input_available/idle/result_rdy/result_taken handshake, and returns each result only to the requester that issued it.
- Reports the engine cycle count of each job.
- Sits between the client models and the GCD engine in the test fixture; one job is in flight at a time.

Parameters:
- W, 16, operand/result width.
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of the grant index; must satisfy 2^IDW >= NREQ.
- CW, 8, width of the per-job cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  requester i has an operand pair pending.
- req_A  input  NREQ*W  operand A of requester i, bits [i*W +: W].
- req_B  input  NREQ*W  operand B of requester i, bits [i*W +: W].
- req_ready  output  NREQ  one-cycle accept pulse to requester i.
- rsp_valid  output  NREQ  result available to requester i.
- rsp_ready  input  NREQ  requester i takes the result.
- rsp_data  output  W  GCD result.
- rsp_cycles  output  CW  engine cycles spent on the job.
- busy  output  1  a job is in flight (any state except ARB).
- grant_id  output  IDW  index of the current or last granted requester.
- core_idle  input  1  engine idle flag.
- core_result_rdy  input  1  engine result ready.
- core_result_data  input  W  engine result.
- core_input_available  output  1  start pulse to the engine.
- core_operand_A  output  W  operand A to the engine.
- core_operand_B  output  W  operand B to the engine.
- core_result_taken  output  1  result acknowledge to the engine.

Behaviour:
- Reset (async, high):
  - state=ARB; rr_ptr=NREQ-1, so requester 0 has top priority first.
  - All outputs 0; latched operands, result and counter 0.
- FSM states: ARB, ISSUE, WAIT_RES, DELIVER.
- ARB:
  - Grant only when core_idle=1 and at least one req_valid bit is set.
  - Winner is the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - Same cycle: req_ready[winner]=1 for exactly one cycle; latch req_A and req_B of the winner; grant_id<=winner.
  - Next state ISSUE. Otherwise stay in ARB.
  - With core_idle=0 there is no grant and req_ready stays 0.
- ISSUE:
  - core_input_available=1 for exactly this one cycle.
  - core_operand_A/B carry the latched values; they are held stable from ISSUE until the next grant.
  - Cycle counter cleared to 1. Next state WAIT_RES.
- WAIT_RES:
  - Counter increments each cycle, saturating at 2^CW-1 (no wrap).
  - On core_result_rdy=1: latch core_result_data into rsp_data and the counter into rsp_cycles; core_result_taken=1 for this cycle only; next state DELIVER.
- DELIVER:
  - rsp_valid[grant_id]=1; all other rsp_valid bits are 0.
  - rsp_data and rsp_cycles are held stable.
  - Wait for rsp_ready[grant_id]. In that cycle: rsp_valid drops next edge, rr_ptr<=grant_id, next state ARB.
  - rsp_ready on non-granted lines is ignored.
- Latency:
  - Grant to ISSUE is 1 cycle; DELIVER entry is 1 cycle after core_result_rdy.
  - A new grant is possible in the cycle after the rsp_ready handshake, provided the engine is idle.
- Fairness: a requester holding req_valid is served within NREQ jobs.
- Request rules: req_valid may drop without penalty while not granted. Operands are sampled only in the grant cycle.
- The arbiter does not special-case zero operands; the engine result passes through unchanged.
- Reset mid-job: the arbiter returns to ARB immediately with all outputs 0. The engine's reset must be asserted together with it (system tie); the arbiter does not re-synchronise with an engine in mid-job.
- rsp_valid and req_ready are never both set for the same index in the same cycle.

Test Plan:
- Single requester, req0=(36,15) -> req_ready[0] pulses 1 cycle; core_input_available pulses in the next cycle; rsp_valid[0] with rsp_data=3; rsp_cycles equals the engine cycle count; core_result_taken pulses exactly once.
- req0=(36,15) and req1=(180,30) asserted simultaneously after reset -> req0 is served first (data 3), then req1 (data 30), with grant_id 0 then 1.
- Both requesters held valid continuously for 4 jobs -> grants alternate 0,1,0,1; req_ready never pulses twice in a row to the same index.
- Backpressure: rsp_ready[0] held low for 10 cycles with req1 pending -> rsp_valid[0] and rsp_data stay stable; no grant to req1 until the handshake completes.
- Boundary operands: (7,0) -> 7; (0,9) -> 9; a long job driving rsp_cycles past 255 with CW=8 -> 255 (saturates).
- Reset asserted during WAIT_RES -> all outputs 0 asynchronously; after release, req0=(36,15) completes normally with data 3.

Source files
------------

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD engine
// between NREQ requesters, with one job in flight at a time.
module gcd_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_A,
  input  logic [NREQ*W-1:0] req_B,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [CW-1:0]     rsp_cycles,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  input  logic              core_idle,
  input  logic              core_result_rdy,
  input  logic [W-1:0]      core_result_data,
  output logic              core_input_available,
  output logic [W-1:0]      core_operand_A,
  output logic [W-1:0]      core_operand_B,
  output logic              core_result_taken
);

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    WAIT_RES,
    DELIVER
  } state_t;

  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] RR_RST  = IDW'(NREQ-1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cyc_q, cyc_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   pos;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           grant;

  // search starts just past the last served requester and wraps
  always_comb begin : pick
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = {1'b0, rr_q} + (IDW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!found && req_valid[pos[IDW-1:0]]) begin
        found = 1'b1;
        win   = pos[IDW-1:0];
      end
    end
  end

  always_comb begin : opsel
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = req_A[i*W +: W];
        b_sel = req_B[i*W +: W];
      end
    end
  end

  assign grant = (state_q == ARB) && core_idle
              && found && !reset;

  always_comb begin : next
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      ARB: begin
        if (grant) begin
          a_d     = a_sel;
          b_d     = b_sel;
          gnt_d   = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(1);
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (core_result_rdy) begin
          res_d   = core_result_data;
          cyc_d   = cnt_q;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (rsp_ready[gnt_q]) begin
          rr_d    = gnt_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      rr_q    <= RR_RST;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin : strobes
    req_ready = '0;
    rsp_valid = '0;
    if (grant) req_ready[win] = 1'b1;
    if (state_q == DELIVER) rsp_valid[gnt_q] = 1'b1;
  end

  assign busy                 = (state_q != ARB);
  assign grant_id             = gnt_q;
  assign rsp_data             = res_q;
  assign rsp_cycles           = cyc_q;
  assign core_operand_A       = a_q;
  assign core_operand_B       = b_q;
  assign core_input_available = (state_q == ISSUE);
  assign core_result_taken    = (state_q == WAIT_RES)
                             && core_result_rdy;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed vectors for gcd_arbiter against a
// behavioural GCD engine with a programmable job latency.
module tb_gcd_arbiter;
  localparam int W    = 16;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ-1:0]   rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_A, req_B;
  logic [W-1:0]      rsp_data;
  logic [CW-1:0]     rsp_cycles;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              core_idle, core_result_rdy;
  logic [W-1:0]      core_result_data;
  logic              core_input_available;
  logic [W-1:0]      core_operand_A, core_operand_B;
  logic              core_result_taken;

  int n_cmp = 0;
  int n_bad = 0;

  gcd_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cycles(rsp_cycles), .busy(busy), .grant_id(grant_id),
    .core_idle(core_idle), .core_result_rdy(core_result_rdy),
    .core_result_data(core_result_data),
    .core_input_available(core_input_available),
    .core_operand_A(core_operand_A),
    .core_operand_B(core_operand_B),
    .core_result_taken(core_result_taken)
  );

  always #5 clk = ~clk;

  // behavioural engine: result_rdy appears in the lat_cfg-th wait cycle
  logic       eng_idle = 1'b1;
  logic       eng_rdy  = 1'b0;
  logic [W-1:0] eng_data = '0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  int         left = 0;
  int         lat_cfg;
  logic       hold_busy;

  assign core_idle        = eng_idle && !hold_busy;
  assign core_result_rdy  = eng_rdy;
  assign core_result_data = eng_data;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      eng_idle <= 1'b1;
      eng_rdy  <= 1'b0;
      left     <= 0;
    end else if (eng_rdy) begin
      eng_rdy  <= 1'b0;
      eng_idle <= 1'b1;
    end else if (core_input_available) begin
      eng_idle <= 1'b0;
      opa      <= core_operand_A;
      opb      <= core_operand_B;
      left     <= lat_cfg;
    end else if (!eng_idle) begin
      left <= left - 1;
      if (left == 1) begin
        eng_rdy  <= 1'b1;
        eng_data <= gcd_f(opa, opb);
      end
    end
  end

  int   taken_cnt = 0;
  int   gn = 0;
  int   glog [8];
  logic mon_clr;

  always @(posedge clk) begin
    if (mon_clr) begin
      taken_cnt <= 0;
      gn        <= 0;
    end else begin
      if (core_result_taken) taken_cnt <= taken_cnt + 1;
      if (req_ready != '0) begin
        if (gn < 8) glog[gn] <= req_ready[1] ? 1 : 0;
        gn <= gn + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input int a, input int b);
    req_valid[idx]       = 1'b1;
    req_A[idx*W +: W]    = W'(a);
    req_B[idx*W +: W]    = W'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_grant(input int idx, input string nm);
    bit got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      if (req_ready[idx]) got = 1'b1;
      else @(negedge clk);
    end
    chk(nm, 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int idx, input int ed, input int ec,
                          input int eg, input bit clr,
                          input string nm);
    bit got = 1'b0;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid[idx]) got = 1'b1;
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
    chk({nm, "_data"}, 32'(rsp_data), ed);
    chk({nm, "_cycles"}, 32'(rsp_cycles), ec);
    chk({nm, "_gid"}, 32'(grant_id), eg);
    chk({nm, "_onehot"}, 32'(rsp_valid), 32'd1 << idx);
    if (clr) req_valid = '0;
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk({nm, "_drop"}, 32'(rsp_valid[idx]), 32'd0);
  endtask

  typedef struct {
    int idx;
    int a;
    int b;
    int lat;
    int ed;
    int ec;
  } vec_t;

  vec_t tab [6];
  bit   ok;
  bit   got4;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{0,    7,   0,   2,   7,   2};
    tab[1] = '{0,    0,   9,   3,   9,   3};
    tab[2] = '{1,   48,  18,   5,   6,   5};
    tab[3] = '{1,  100,  75,   1,  25,   1};
    tab[4] = '{0,   17,   5,   6,   1,   6};
    tab[5] = '{1, 1000, 600, 300, 200, 255};

    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_A     = '0;
    req_B     = '0;
    hold_busy = 1'b0;
    lat_cfg   = 1;
    mon_clr   = 1'b1;

    #12;
    chk("rst_outs", 32'(|{req_ready, rsp_valid, rsp_data,
        rsp_cycles, busy, grant_id, core_input_available,
        core_operand_A, core_operand_B, core_result_taken}), 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // single job, exact strobe timing
    @(negedge clk);
    mon_clr = 1'b0;
    lat_cfg = 4;
    set_req(0, 36, 15);
    #1 chk("t1_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    chk("t1_ready_once", 32'(req_ready), 0);
    chk("t1_issue", 32'(core_input_available), 1);
    chk("t1_opA", 32'(core_operand_A), 36);
    chk("t1_opB", 32'(core_operand_B), 15);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_issue_once", 32'(core_input_available), 0);
    wait_rsp(0, 3, 4, 0, 1'b0, "t1");
    chk("t1_taken", 32'(taken_cnt), 1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat_cfg = tab[i].lat;
      set_req(tab[i].idx, tab[i].a, tab[i].b);
      wait_grant(tab[i].idx, $sformatf("vec%0d_grant", i));
      req_valid = '0;
      wait_rsp(tab[i].idx, tab[i].ed, tab[i].ec, tab[i].idx,
               1'b0, $sformatf("vec%0d", i));
    end

    // simultaneous requests right after reset
    do_reset();
    @(negedge clk);
    lat_cfg = 3;
    set_req(0, 36, 15);
    set_req(1, 180, 30);
    #1 chk("t2_first", 32'(req_ready), 32'd1);
    wait_grant(0, "t2_g0");
    req_valid[0] = 1'b0;
    wait_rsp(0, 3, 3, 0, 1'b0, "t2a");
    chk("t2_next", 32'(req_ready), 32'd2);
    wait_grant(1, "t2_g1");
    req_valid = '0;
    wait_rsp(1, 30, 3, 1, 1'b0, "t2b");

    // both held valid for four jobs
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    lat_cfg = 2;
    set_req(0, 36, 15);
    set_req(1, 180, 30);
    wait_rsp(0, 3, 2, 0, 1'b0, "t3a");
    wait_rsp(1, 30, 2, 1, 1'b0, "t3b");
    wait_rsp(0, 3, 2, 0, 1'b0, "t3c");
    wait_rsp(1, 30, 2, 1, 1'b1, "t3d");
    chk("t3_ngrants", 32'(gn), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_order%0d", k), 32'(glog[k]), k % 2);

    // backpressure with the other requester pending
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    lat_cfg = 3;
    set_req(0, 36, 15);
    set_req(1, 180, 30);
    got4 = 1'b0;
    for (int t = 0; t < 100 && !got4; t++) begin
      @(negedge clk);
      if (rsp_valid[0]) got4 = 1'b1;
    end
    chk("t4_seen", 32'(got4), 1);
    req_valid[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok = ok && (rsp_valid == 2'b01) && (rsp_data == 16'd3)
         && (rsp_cycles == 8'd3) && (req_ready == '0);
    end
    chk("t4_hold", 32'(ok), 1);
    chk("t4_nogrant", 32'(gn), 1);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    chk("t4_release", 32'(rsp_valid), 0);
    wait_grant(1, "t4_g1");
    req_valid = '0;
    wait_rsp(1, 30, 3, 1, 1'b0, "t4b");

    // engine busy blocks any grant
    @(negedge clk);
    hold_busy = 1'b1;
    lat_cfg   = 2;
    set_req(0, 48, 18);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok = ok && (req_ready == '0) && !busy;
    end
    chk("t5_blocked", 32'(ok), 1);
    hold_busy = 1'b0;
    wait_grant(0, "t5_g");
    req_valid = '0;
    wait_rsp(0, 6, 2, 0, 1'b0, "t5");

    // reset in the middle of a job
    @(negedge clk);
    lat_cfg = 50;
    set_req(0, 36, 15);
    wait_grant(0, "t6_g");
    repeat (5) @(negedge clk);
    chk("t6_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_outs", 32'(|{req_ready, rsp_valid, rsp_data,
        rsp_cycles, busy, grant_id, core_input_available,
        core_operand_A, core_operand_B, core_result_taken}), 0);
    chk("t6_rst_data", 32'(rsp_data), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    lat_cfg = 4;
    set_req(0, 36, 15);
    wait_grant(0, "t6_g2");
    req_valid = '0;
    wait_rsp(0, 3, 4, 0, 1'b0, "t6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
